// File: rtl/des_key_schedule.sv
// DES subkey generator: PC-1 on load, then one PC-2 subkey per clock for 16 rounds,
// forward (encrypt) or reverse (decrypt) order, with optional byte odd-parity check.
module des_key_schedule #(
    parameter bit CHECK_PARITY = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] key_in,
    input  logic        load,
    input  logic        decrypt,
    output logic [47:0] subkey_out,
    output logic [3:0]  round_idx,
    output logic        subkey_valid,
    output logic        busy,
    output logic        done,
    output logic        parity_err
);

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Bit r set = round r+1 shifts by one position (rounds 1, 2, 9, 16)
    localparam logic [15:0] SHIFT_ONE = 16'b1000_0001_0000_0011;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_nxt;
    logic [27:0] c_q, d_q;
    logic [3:0]  cnt_q;
    logic        dir_q;

    logic        accept;
    logic [3:0]  step_idx;
    logic        one;
    logic [27:0] c_l, d_l, c_r, d_r;
    logic [47:0] key_cur;

    // DES bit i of the key is key_in[64-i]; of a 56-bit C||D word it is cd[56-i]
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        for (int j = 0; j < 56; j++) r[55-j] = k[64-PC1[j]];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        for (int j = 0; j < 48; j++) r[47-j] = cd[56-PC2[j]];
        return r;
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic by1);
        return by1 ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic by1);
        return by1 ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    function automatic logic even_byte(input logic [63:0] k);
        logic e;
        e = 1'b0;
        for (int b = 0; b < 8; b++) e = e | ~(^k[8*b +: 8]);
        return e;
    endfunction

    // The 16th step doubles as an acceptance slot so schedules chain without a bubble
    assign accept   = load && ((state == IDLE) || (cnt_q == 4'd15));
    assign step_idx = dir_q ? (4'd15 - cnt_q) : cnt_q;
    assign one      = SHIFT_ONE[step_idx];
    assign c_l      = rotl(c_q, one);
    assign d_l      = rotl(d_q, one);
    assign c_r      = rotr(c_q, one);
    assign d_r      = rotr(d_q, one);
    // Encrypt rotates then emits; decrypt emits then undoes this round's rotation
    assign key_cur  = dir_q ? pc2({c_q, d_q}) : pc2({c_l, d_l});

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (load) state_nxt = RUN;
            RUN:  if (cnt_q == 4'd15) state_nxt = load ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_q        <= '0;
            d_q        <= '0;
            cnt_q      <= '0;
            dir_q      <= 1'b0;
            parity_err <= 1'b0;
        end else if (accept) begin
            {c_q, d_q} <= pc1(key_in);
            dir_q      <= decrypt;
            cnt_q      <= '0;
            parity_err <= CHECK_PARITY ? even_byte(key_in) : 1'b0;
        end else if (state == RUN) begin
            c_q   <= dir_q ? c_r : c_l;
            d_q   <= dir_q ? d_r : d_l;
            cnt_q <= cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            subkey_out   <= '0;
            round_idx    <= '0;
            subkey_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else if (state == RUN) begin
            subkey_out   <= key_cur;
            round_idx    <= step_idx;
            subkey_valid <= 1'b1;
            busy         <= 1'b1;
            done         <= (cnt_q == 4'd15);
        end else begin
            subkey_out   <= '0;
            round_idx    <= '0;
            subkey_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end
    end

endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule: directed and random keys checked against a
// bit-array DES key-schedule model built from cumulative rotations.
module tb_des_key_schedule;

    logic        clk;
    logic        reset;
    logic [63:0] key_in;
    logic        load;
    logic        decrypt;
    logic [47:0] subkey_out;
    logic [3:0]  round_idx;
    logic        subkey_valid;
    logic        busy;
    logic        done;
    logic        parity_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [47:0] exp_k [1:16];
    logic [47:0] exp_a [1:16];
    logic        exp_par;
    logic [47:0] obs_first, obs_last;

    int PC1_T [1:56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    int PC2_T [1:48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    int SH_T [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    des_key_schedule #(.CHECK_PARITY(1'b1)) dut (
        .clk(clk), .reset(reset), .key_in(key_in), .load(load), .decrypt(decrypt),
        .subkey_out(subkey_out), .round_idx(round_idx), .subkey_valid(subkey_valid),
        .busy(busy), .done(done), .parity_err(parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // K_n from C0/D0 rotated left by the cumulative shift count, per DES tables
    task automatic model(input logic [63:0] key);
        logic cd0 [1:56];
        logic cn  [1:56];
        logic [47:0] k;
        int cum;
        int ones;
        for (int i = 1; i <= 56; i++) cd0[i] = key[64 - PC1_T[i]];
        cum = 0;
        for (int n = 1; n <= 16; n++) begin
            cum += SH_T[n];
            for (int i = 1; i <= 28; i++) begin
                cn[i]      = cd0[((i - 1 + cum) % 28) + 1];
                cn[28 + i] = cd0[28 + ((i - 1 + cum) % 28) + 1];
            end
            for (int j = 1; j <= 48; j++) k[48 - j] = cn[PC2_T[j]];
            exp_k[n] = k;
        end
        exp_par = 1'b0;
        for (int b = 0; b < 8; b++) begin
            ones = $countones(key[8*b +: 8]);
            if (ones % 2 == 0) exp_par = 1'b1;
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, {63'd0, subkey_valid}, 64'd0);
        chk({tag, "_busy"},  {63'd0, busy}, 64'd0);
        chk({tag, "_done"},  {63'd0, done}, 64'd0);
        chk({tag, "_key"},   {16'd0, subkey_out}, 64'd0);
        chk({tag, "_idx"},   {60'd0, round_idx}, 64'd0);
    endtask

    task automatic check_step(input string tag, input int k, input logic dec, input logic [47:0] ek);
        int n;
        n = dec ? 17 - k : k;
        chk({tag, "_valid"}, {63'd0, subkey_valid}, 64'd1);
        chk({tag, "_busy"},  {63'd0, busy}, 64'd1);
        chk({tag, "_idx"},   {60'd0, round_idx}, 64'(n - 1));
        chk({tag, "_key"},   {16'd0, subkey_out}, {16'd0, ek});
        chk({tag, "_done"},  {63'd0, done}, {63'd0, (k == 16)});
    endtask

    // One schedule; inputs scrambled after acceptance, load pulses during steps 2..15
    task automatic run_sched(input string tag, input logic [63:0] key, input logic dec);
        int n;
        @(negedge clk);
        key_in = key; decrypt = dec; load = 1'b1;
        model(key);
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        key_in = {$urandom, $urandom};
        decrypt = 1'($urandom_range(0, 1));
        chk({tag, "_parity"}, {63'd0, parity_err}, {63'd0, exp_par});
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            @(negedge clk);
            n = dec ? 17 - k : k;
            check_step(tag, k, dec, exp_k[n]);
            if (k == 1)  obs_first = subkey_out;
            if (k == 16) obs_last  = subkey_out;
            key_in = {$urandom, $urandom};
            load = (k <= 14) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        check_idle({tag, "_after"});
        chk({tag, "_parity_hold"}, {63'd0, parity_err}, {63'd0, exp_par});
    endtask

    initial begin
        reset = 1'b1; load = 1'b1; decrypt = 1'b0; key_in = 64'h133457799BBCDFF1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        chk("reset_parity", {63'd0, parity_err}, 64'd0);
        reset = 1'b0; load = 1'b0;

        // Reference key, both directions
        run_sched("enc_ref", 64'h133457799BBCDFF1, 1'b0);
        chk("enc_ref_first", {16'd0, obs_first}, 64'h1B02EFFC7072);
        chk("enc_ref_last",  {16'd0, obs_last},  64'hCB3D8B0E17F5);
        run_sched("dec_ref", 64'h133457799BBCDFF1, 1'b1);
        chk("dec_ref_first", {16'd0, obs_first}, 64'hCB3D8B0E17F5);
        chk("dec_ref_last",  {16'd0, obs_last},  64'h1B02EFFC7072);

        // Parity corner keys
        run_sched("par_ok", 64'h0101010101010101, 1'b0);
        chk("par_ok_key", {16'd0, obs_first}, 64'd0);
        chk("par_ok_flag", {63'd0, parity_err}, 64'd0);
        run_sched("par_bad", 64'h0000000000000000, 1'b0);
        chk("par_bad_key", {16'd0, obs_last}, 64'd0);
        chk("par_bad_flag", {63'd0, parity_err}, 64'd1);

        // Random keys and directions
        for (int r = 0; r < 6; r++)
            run_sched("rand", {$urandom, $urandom}, 1'($urandom_range(0, 1)));

        // Back-to-back: load held high, second key/direction presented for the chained slot
        begin
            logic [63:0] ka, kb;
            ka = {$urandom, $urandom};
            kb = {$urandom, $urandom};
            model(ka);
            for (int i = 1; i <= 16; i++) exp_a[i] = exp_k[i];
            model(kb);
            @(negedge clk);
            key_in = ka; decrypt = 1'b0; load = 1'b1;
            @(posedge clk);
            @(negedge clk);
            key_in = kb; decrypt = 1'b1;
            for (int k = 1; k <= 32; k++) begin
                @(posedge clk);
                @(negedge clk);
                if (k <= 16) check_step("b2b_a", k, 1'b0, exp_a[k]);
                else         check_step("b2b_b", k - 16, 1'b1, exp_k[33 - k]);
                if (k == 16) load = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            check_idle("b2b_after");
        end

        // Asynchronous reset while round_idx = 5
        begin
            bit seen;
            seen = 1'b0;
            model(64'h0F1E2D3C4B5A6978);
            @(negedge clk);
            key_in = 64'h0F1E2D3C4B5A6978; decrypt = 1'b0; load = 1'b1;
            @(posedge clk);
            @(negedge clk);
            load = 1'b0;
            for (int k = 1; k <= 20 && !seen; k++) begin
                @(posedge clk);
                @(negedge clk);
                if (round_idx == 4'd5 && subkey_valid) seen = 1'b1;
            end
            chk("arst_reach_idx5", {63'd0, seen}, 64'd1);
            chk("arst_key_idx5", {16'd0, subkey_out}, {16'd0, exp_k[6]});
            #1 reset = 1'b1;
            #1;
            check_idle("arst_mid");
            chk("arst_parity", {63'd0, parity_err}, 64'd0);
            @(negedge clk);
            reset = 1'b0;
            run_sched("post_arst", 64'h133457799BBCDFF1, 1'b0);
            chk("post_arst_first", {16'd0, obs_first}, 64'h1B02EFFC7072);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/des_key_schedule.md
DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

Interface
REQ-001 Parameter CHECK_PARITY, default 1, meaning: 1 = evaluate DES odd parity on each accepted key; 0 = parity_err tied to 0.
REQ-002 clk  input  1  rising-edge clock; the block's only clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 key_in  input  64  DES key; bit 63 = DES bit 1; parity bits are key_in[56], [48], ..., [0].
REQ-005 load  input  1  start request; key_in and decrypt are sampled on the clk edge where the start is accepted.
REQ-006 decrypt  input  1  0 = emit K1..K16; 1 = emit K16..K1.
REQ-007 subkey_out  output  48  current round subkey; bit 47 = PC-2 output bit 1.
REQ-008 round_idx  output  4  DES round number minus 1 of the key on subkey_out.
REQ-009 subkey_valid  output  1  subkey_out/round_idx valid this cycle.
REQ-010 busy  output  1  schedule in progress.
REQ-011 done  output  1  one-cycle pulse coincident with the 16th subkey.
REQ-012 parity_err  output  1  registered; 1 if any byte of the last accepted key has even parity.

Function
REQ-013 FSM states SHALL be IDLE and RUN; the reset state is IDLE.
REQ-014 In IDLE, load=1 SHALL be accepted: C/D <= PC-1(key_in), direction latched, parity_err updated, state -> RUN, counter <= 0.
REQ-015 In RUN, load SHALL be ignored, except in the done cycle, where it is accepted as in REQ-014 (back-to-back, no bubble).
REQ-016 Latency: load accepted at edge t -> subkey_valid=1 for the 16 cycles following edges t+1..t+16, one subkey per cycle, no gaps.
REQ-017 Encrypt: the key presented in step n (n=1..16) SHALL be K_n = PC-2(C_n,D_n); C/D each rotate left 1 in rounds 1, 2, 9, 16 and left 2 otherwise; round_idx = n-1.
REQ-018 Decrypt: the first key presented SHALL be K16 = PC-2(C0,D0) with round_idx=15; each following step rotates C/D right by the shift of the round just emitted (1,2,2,2,2,2,2,1,2,2,2,2,2,2,1) and decrements round_idx down to 0.
REQ-019 C and D SHALL be independent 28-bit registers with wrap-around rotation; the cumulative shift after 16 rounds equals 28, so C/D return to PC-1 value.
REQ-020 busy=1 from the cycle after acceptance through the done cycle; busy=subkey_valid.
REQ-021 done=1 only with the 16th subkey (round_idx 15 encrypt, 0 decrypt); the next state is IDLE unless reloaded.
REQ-022 When subkey_valid=0, subkey_out and round_idx SHALL be driven to 0.
REQ-023 Changes on key_in/decrypt after acceptance SHALL NOT affect the running schedule.
REQ-024 parity_err SHALL hold its value until the next accepted load; it never blocks operation.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 reset=1 SHALL asynchronously force state IDLE and C, D, counter, direction, subkey_out, round_idx, subkey_valid, busy, done and parity_err to 0, including mid-schedule.
REQ-027 load while reset=1 SHALL be ignored; first acceptance is possible on the first clk edge after reset deasserts.

Verification
REQ-028 key_in=133457799BBCDFF1, decrypt=0, one load pulse -> first subkey_out=1B02EFFC7072 with round_idx 0; last=CB3D8B0E17F5 with round_idx 15 and done=1; parity_err=0.
REQ-029 Same key, decrypt=1 -> first subkey_out=CB3D8B0E17F5 with round_idx 15; last=1B02EFFC7072 with round_idx 0 and done=1; sequence is the exact reverse of REQ-028.
REQ-030 key_in=0101010101010101 -> 16 subkeys all 000000000000, parity_err=0; key_in=0000000000000000 -> same subkeys, parity_err=1.
REQ-031 load held high continuously with alternating keys -> schedules are back-to-back (32 consecutive valid cycles); load pulses during cycles 2-15 of RUN have no effect.
REQ-032 reset asserted asynchronously while round_idx=5 -> all outputs 0 before the next clk edge; load after release gives a clean K1..K16 sequence.
REQ-033 key_in changed on the cycle after acceptance -> all 16 subkeys match the originally accepted key.
